// File: rtl/mac_array_seq.sv
// Multi-lane signed MAC: shared activation, per-lane weights and bias, requantised valid/ready output.
// Optional build macro MAC_ARRAY_RELU_EN clamps negative lane results to zero after saturation.
module mac_array_seq #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 4,
   parameter int CNT_W  = 10
) (
   input  logic                      CLKEXT,
   input  logic                      RSTN_MAC,
   input  logic                      START,
   input  logic [CNT_W-1:0]          VEC_LEN,
   input  logic [LANES*DATA_W-1:0]   BIAS_IN,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [DATA_W-1:0]         A_IN,
   input  logic [LANES*DATA_W-1:0]   W_IN,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [LANES*OUT_W-1:0]    RESULT,
   output logic                      BUSY
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_QUANT = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [1:0]                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d, len_q, len_d, cnt_inc;
   logic signed [ACC_W-1:0]   acc_q [LANES];
   logic signed [ACC_W-1:0]   acc_d [LANES];
   logic [LANES*OUT_W-1:0]    result_q, result_d;

   function automatic logic signed [ACC_W-1:0] sext_bias(input logic signed [DATA_W-1:0] b);
      return {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
   endfunction

   function automatic logic signed [ACC_W-1:0] mac_add(input logic signed [ACC_W-1:0] acc,
                                                       input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] w);
      logic signed [2*DATA_W-1:0] p;
      p = a * w;
      // Wraps modulo 2^ACC_W by design; saturation happens only at requantisation.
      return acc + {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
   endfunction

   function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      logic signed [OUT_W-1:0] r;
      sh = acc >>> SHIFT;
      if (sh > SAT_MAX)
         r = SAT_MAX[OUT_W-1:0];
      else if (sh < SAT_MIN)
         r = SAT_MIN[OUT_W-1:0];
      else
         r = sh[OUT_W-1:0];
`ifdef MAC_ARRAY_RELU_EN
      if (r[OUT_W-1])
         r = '0;
`endif
      return r;
   endfunction

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      result_d = result_q;
      for (int i = 0; i < LANES; i++)
         acc_d[i] = acc_q[i];
      case (state_q)
         S_IDLE: begin
            if (START) begin
               for (int i = 0; i < LANES; i++)
                  acc_d[i] = sext_bias(BIAS_IN[i*DATA_W +: DATA_W]);
               cnt_d   = '0;
               len_d   = VEC_LEN;
               state_d = (VEC_LEN != '0) ? S_ACCUM : S_QUANT;
            end
         end
         S_ACCUM: begin
            if (IN_VALID) begin
               for (int i = 0; i < LANES; i++)
                  acc_d[i] = mac_add(acc_q[i], A_IN, W_IN[i*DATA_W +: DATA_W]);
               cnt_d = cnt_inc;
               if (cnt_inc == len_q)
                  state_d = S_QUANT;
            end
         end
         S_QUANT: begin
            for (int i = 0; i < LANES; i++)
               result_d[i*OUT_W +: OUT_W] = requant(acc_q[i]);
            state_d = S_OUT;
         end
         S_OUT: begin
            if (OUT_READY)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLKEXT or negedge RSTN_MAC) begin
      if (!RSTN_MAC) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         result_q <= '0;
         for (int i = 0; i < LANES; i++)
            acc_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         result_q <= result_d;
         for (int i = 0; i < LANES; i++)
            acc_q[i] <= acc_d[i];
      end
   end

   // Handshake flags decode straight from state so reset drops them immediately.
   assign IN_READY  = (state_q == S_ACCUM);
   assign OUT_VALID = (state_q == S_OUT);
   assign BUSY      = (state_q != S_IDLE);
   assign RESULT    = result_q;

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed table-driven bench for mac_array_seq, plus hand-written reset, gap and backpressure sequences.
module tb_mac_array_seq;
   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int ACC_W  = 24;
   localparam int OUT_W  = 8;
   localparam int SHIFT  = 4;
   localparam int CNT_W  = 10;

   logic                    CLKEXT = 1'b0;
   logic                    RSTN_MAC = 1'b0;
   logic                    START = 1'b0;
   logic [CNT_W-1:0]        VEC_LEN = '0;
   logic [LANES*DATA_W-1:0] BIAS_IN = '0;
   logic                    IN_VALID = 1'b0;
   logic                    IN_READY;
   logic [DATA_W-1:0]       A_IN = '0;
   logic [LANES*DATA_W-1:0] W_IN = '0;
   logic                    OUT_VALID;
   logic                    OUT_READY = 1'b0;
   logic [LANES*OUT_W-1:0]  RESULT;
   logic                    BUSY;

   mac_array_seq #(
      .DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W),
      .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)
   ) dut (
      .CLKEXT(CLKEXT), .RSTN_MAC(RSTN_MAC), .START(START), .VEC_LEN(VEC_LEN),
      .BIAS_IN(BIAS_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A_IN(A_IN),
      .W_IN(W_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT),
      .BUSY(BUSY)
   );

   always #5 CLKEXT = ~CLKEXT;

   typedef struct packed {
      logic [CNT_W-1:0]          len;
      logic [LANES*DATA_W-1:0]   bias;
      logic [4*DATA_W-1:0]       a;
      logic [4*LANES*DATA_W-1:0] w;
      logic [LANES*OUT_W-1:0]    exp;
   } vec_t;

   vec_t vt [4];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Starts an operation and feeds beats; vpat bit per slot selects IN_VALID.
   task automatic start_and_feed(input int idx, input logic [15:0] vpat);
      int k;
      int slot;
      k = 0;
      slot = 0;
      @(negedge CLKEXT);
      START = 1'b1; VEC_LEN = vt[idx].len; BIAS_IN = vt[idx].bias;
      @(negedge CLKEXT);
      START = 1'b0; VEC_LEN = '1; BIAS_IN = '1;
      chk("busy_after_start", BUSY, 1);
      if (vt[idx].len == '0)
         chk("in_ready_len0", IN_READY, 0);
      while (k < int'(vt[idx].len) && slot < 16) begin
         chk("in_ready_accum", IN_READY, 1);
         if (vpat[slot]) begin
            IN_VALID = 1'b1;
            A_IN = vt[idx].a[k*DATA_W +: DATA_W];
            W_IN = vt[idx].w[k*LANES*DATA_W +: LANES*DATA_W];
            k++;
         end else begin
            IN_VALID = 1'b0;
            A_IN = 8'h55;
            W_IN = '1;
         end
         slot++;
         @(negedge CLKEXT);
      end
      IN_VALID = 1'b0; A_IN = '0; W_IN = '0;
      chk("out_valid_in_quant", OUT_VALID, 0);
      chk("in_ready_in_quant", IN_READY, 0);
      @(negedge CLKEXT);
      chk("out_valid_rise", OUT_VALID, 1);
      chk("result", RESULT, vt[idx].exp);
   endtask

   task automatic handshake(input logic with_start, input logic [LANES*OUT_W-1:0] exp);
      OUT_READY = 1'b1; START = with_start; VEC_LEN = '0; BIAS_IN = '0;
      @(negedge CLKEXT);
      OUT_READY = 1'b0; START = 1'b0;
      chk("out_valid_fall", OUT_VALID, 0);
      chk("busy_idle", BUSY, 0);
      chk("result_hold_idle", RESULT, exp);
   endtask

   initial begin
      // Lane packing: lane3 in the top byte, beat0 in the low bits.
      vt[0].len  = 10'd3;
      vt[0].bias = {8'h00, 8'h00, 8'hF0, 8'h05};
      vt[0].a    = {8'h00, 8'h04, 8'h03, 8'h02};
      vt[0].w    = {32'h0, 32'hFF010001, 32'hFF0100FF, 32'hFF01000A};
      vt[1].len  = 10'd2;
      vt[1].bias = 32'h0;
      vt[1].a    = {8'h00, 8'h00, 8'h7F, 8'h7F};
      vt[1].w    = {32'h0, 32'h0, 32'h0100807F, 32'h0100807F};
      vt[2].len  = 10'd2;
      vt[2].bias = {8'hFF, 8'h00, 8'h00, 8'h00};
      vt[2].a    = {8'h00, 8'h00, 8'h80, 8'h80};
      vt[2].w    = {32'h0, 32'h0, 32'h0001807F, 32'h0001807F};
      vt[3].len  = 10'd0;
      vt[3].bias = {8'h0F, 8'h80, 8'h7F, 8'h20};
      vt[3].a    = '0;
      vt[3].w    = '0;
`ifdef MAC_ARRAY_RELU_EN
      vt[0].exp = {8'h00, 8'h00, 8'h00, 8'h01};
      vt[1].exp = {8'h0F, 8'h00, 8'h00, 8'h7F};
      vt[2].exp = {8'h00, 8'h00, 8'h7F, 8'h00};
      vt[3].exp = {8'h00, 8'h00, 8'h07, 8'h02};
`else
      vt[0].exp = {8'hFF, 8'h00, 8'hFF, 8'h01};
      vt[1].exp = {8'h0F, 8'h00, 8'h80, 8'h7F};
      vt[2].exp = {8'hFF, 8'hF0, 8'h7F, 8'h80};
      vt[3].exp = {8'h00, 8'hF8, 8'h07, 8'h02};
`endif

      repeat (2) @(negedge CLKEXT);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_result", RESULT, 0);
      RSTN_MAC = 1'b1;

      for (int i = 0; i < 4; i++) begin
         start_and_feed(i, 16'hFFFF);
         handshake(1'b0, vt[i].exp);
      end

      // IN_VALID pattern 1,0,0,1,1 must give the same result as the gap-free run.
      start_and_feed(0, 16'b1_1001);
      handshake(1'b0, vt[0].exp);

      // Backpressure with ignored START pulses, then START coinciding with the handshake.
      start_and_feed(1, 16'hFFFF);
      for (int c = 0; c < 5; c++) begin
         START = 1'b1; VEC_LEN = '0; BIAS_IN = '1;
         @(negedge CLKEXT);
         chk("bp_out_valid", OUT_VALID, 1);
         chk("bp_result", RESULT, vt[1].exp);
         chk("bp_busy", BUSY, 1);
      end
      START = 1'b0;
      handshake(1'b1, vt[1].exp);
      @(negedge CLKEXT);
      chk("start_on_handshake_ignored", BUSY, 0);

      // Reset asserted mid-ACCUM aborts with no output.
      @(negedge CLKEXT);
      START = 1'b1; VEC_LEN = vt[0].len; BIAS_IN = vt[0].bias;
      @(negedge CLKEXT);
      START = 1'b0;
      IN_VALID = 1'b1; A_IN = 8'h02; W_IN = 32'hFF01000A;
      @(negedge CLKEXT);
      chk("pre_rst_in_ready", IN_READY, 1);
      RSTN_MAC = 1'b0;
      IN_VALID = 1'b0;
      #1;
      chk("midrst_out_valid", OUT_VALID, 0);
      chk("midrst_busy", BUSY, 0);
      chk("midrst_in_ready", IN_READY, 0);
      chk("midrst_result", RESULT, 0);
      @(negedge CLKEXT);
      RSTN_MAC = 1'b1;
      repeat (4) begin
         @(negedge CLKEXT);
         chk("post_rst_idle_busy", BUSY, 0);
         chk("post_rst_no_output", OUT_VALID, 0);
      end

      start_and_feed(0, 16'hFFFF);
      handshake(1'b0, vt[0].exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
